// File: rtl/semaforo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_pkg
// Description : Shared types and helpers for the timed two-way traffic light.
//               Holds the phase (fase) codes, the lamp bundle type with its
//               reset/decode constants, and the per-approach lamp decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package semaforo_pkg;

    localparam int FASE_W = 3;

    // Phase codes double as the debug "fase" output value.
    typedef enum logic [FASE_W-1:0] {
        VERM_A   = 3'd0,   // all red, NS gets green next
        NS_VERDE = 3'd1,
        NS_AMAR  = 3'd2,
        VERM_B   = 3'd3,   // all red, LO gets green next
        LO_VERDE = 3'd4,
        LO_AMAR  = 3'd5,
        PISCA    = 3'd6    // flashing-yellow fault mode
    } fase_e;

    typedef struct packed {
        logic verde;
        logic amarelo;
        logic vermelho;
    } lampada_t;

    localparam lampada_t c_LAMP_VERMELHO = '{verde: 1'b0, amarelo: 1'b0, vermelho: 1'b1};
    localparam lampada_t c_LAMP_AMARELO  = '{verde: 1'b0, amarelo: 1'b1, vermelho: 1'b0};
    localparam lampada_t c_LAMP_VERDE    = '{verde: 1'b1, amarelo: 1'b0, vermelho: 1'b0};

    // Lamp decode for one approach. st_verde/st_amar name the two phases in
    // which this approach is not red; every other normal phase shows red.
    function automatic lampada_t decodifica_lampada(
        input logic [FASE_W-1:0] f,
        input logic              pisca,
        input logic [FASE_W-1:0] st_verde,
        input logic [FASE_W-1:0] st_amar
    );
        lampada_t l;
        l = c_LAMP_VERMELHO;
        if (f == PISCA) begin
            l = '{verde: 1'b0, amarelo: pisca, vermelho: 1'b0};
        end else if (f == st_verde) begin
            l = c_LAMP_VERDE;
        end else if (f == st_amar) begin
            l = c_LAMP_AMARELO;
        end
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/semaforo_if.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_if
// Description : Sensor/control inputs and lamp/debug outputs of one
//               intersection controller.
//               master : sensor conditioning side (drives tick, sens_*, falha)
//               slave  : the controller (drives lamps and fase)
// Revision    : 1.0 - initial release
// ============================================================================
interface semaforo_if #(
    parameter int N_SENS_NS = 2,
    parameter int N_SENS_LO = 2
) ();

    logic                               tick;
    logic [N_SENS_NS-1:0]               sens_ns;
    logic [N_SENS_LO-1:0]               sens_lo;
    logic                               falha;
    logic                               ns_verde;
    logic                               ns_amarelo;
    logic                               ns_vermelho;
    logic                               lo_verde;
    logic                               lo_amarelo;
    logic                               lo_vermelho;
    logic [semaforo_pkg::FASE_W-1:0]    fase;

    modport master (
        output tick, sens_ns, sens_lo, falha,
        input  ns_verde, ns_amarelo, ns_vermelho,
        input  lo_verde, lo_amarelo, lo_vermelho, fase
    );

    modport slave (
        input  tick, sens_ns, sens_lo, falha,
        output ns_verde, ns_amarelo, ns_vermelho,
        output lo_verde, lo_amarelo, lo_vermelho, fase
    );

endinterface
`default_nettype wire

// File: rtl/semaforo_timer.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_timer
// Description : Saturating phase timer with tick enable and synchronous clear,
//               plus the "elapsed" compares used by the phase FSM.
// Ports       : clk, rst_n        clock / async active-low reset
//               i_tick            advance enable
//               i_clr             synchronous clear (phase change)
//               o_fim_vermelho    all-red clearance elapsed this cycle
//               o_fim_amarelo     yellow elapsed this cycle
//               o_min_verde       minimum green elapsed or past
//               o_max_verde       maximum green elapsed or past
// Revision    : 1.0 - initial release
// ============================================================================
module semaforo_timer #(
    parameter int CNT_W       = 8,
    parameter int T_VERDE_MIN = 8,
    parameter int T_VERDE_MAX = 32,
    parameter int T_AMARELO   = 3,
    parameter int T_VERMELHO  = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_tick,
    input  wire logic i_clr,
    output logic      o_fim_vermelho,
    output logic      o_fim_amarelo,
    output logic      o_min_verde,
    output logic      o_max_verde
);

    // Terminal counts: a duration of T ticks ends when the timer reads T-1
    // and a tick arrives.
    localparam logic [CNT_W-1:0] c_ULT_VERDE_MIN = CNT_W'(T_VERDE_MIN - 1);
    localparam logic [CNT_W-1:0] c_ULT_VERDE_MAX = CNT_W'(T_VERDE_MAX - 1);
    localparam logic [CNT_W-1:0] c_ULT_AMARELO   = CNT_W'(T_AMARELO - 1);
    localparam logic [CNT_W-1:0] c_ULT_VERMELHO  = CNT_W'(T_VERMELHO - 1);

    logic [CNT_W-1:0] r_cnt;

    // ou_mais selects "elapsed or past", needed for green phases where the
    // timer keeps counting (and saturates) while the phase is held.
    function automatic logic decorrido(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] ult,
        input logic             tick,
        input logic             ou_mais
    );
        return tick && (ou_mais ? (cnt >= ult) : (cnt == ult));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_tick && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_fim_vermelho = decorrido(r_cnt, c_ULT_VERMELHO,  i_tick, 1'b0);
    assign o_fim_amarelo  = decorrido(r_cnt, c_ULT_AMARELO,   i_tick, 1'b0);
    assign o_min_verde    = decorrido(r_cnt, c_ULT_VERDE_MIN, i_tick, 1'b1);
    assign o_max_verde    = decorrido(r_cnt, c_ULT_VERDE_MAX, i_tick, 1'b1);

endmodule
`default_nettype wire

// File: rtl/semaforo_temporizado.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_temporizado
// Description : Timed, demand-driven two-way traffic light controller with a
//               flashing-yellow fault mode. Lamps are registered (Moore).
// Ports       : clk     system clock, rising edge
//               rst_n   asynchronous active-low reset
//               bus     semaforo_if.slave:
//                         tick            timebase enable
//                         sens_ns/sens_lo vehicle-present flags
//                         falha           fault request (level)
//                         ns_*/lo_*       lamp outputs
//                         fase            current phase code (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module semaforo_temporizado #(
    parameter int N_SENS_NS   = 2,
    parameter int N_SENS_LO   = 2,
    parameter int T_VERDE_MIN = 8,
    parameter int T_VERDE_MAX = 32,
    parameter int T_AMARELO   = 3,
    parameter int T_VERMELHO  = 2,
    parameter int CNT_W       = 8
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    semaforo_if.slave  bus
);

    import semaforo_pkg::*;

    localparam logic [FASE_W-1:0] c_VERM_A   = VERM_A;
    localparam logic [FASE_W-1:0] c_NS_VERDE = NS_VERDE;
    localparam logic [FASE_W-1:0] c_NS_AMAR  = NS_AMAR;
    localparam logic [FASE_W-1:0] c_VERM_B   = VERM_B;
    localparam logic [FASE_W-1:0] c_LO_VERDE = LO_VERDE;
    localparam logic [FASE_W-1:0] c_LO_AMAR  = LO_AMAR;
    localparam logic [FASE_W-1:0] c_PISCA    = PISCA;

    logic              w_dem_ns;
    logic              w_dem_lo;
    logic [FASE_W-1:0] r_fase;
    logic [FASE_W-1:0] w_fase_nxt;
    logic              r_pisca;
    logic              w_pisca_nxt;
    logic              w_troca;
    logic              w_fim_vermelho;
    logic              w_fim_amarelo;
    logic              w_min_verde;
    logic              w_max_verde;
    lampada_t          r_lamp_ns;
    lampada_t          r_lamp_lo;

    // Demand is the live OR of the sensors; nothing is latched.
    assign w_dem_ns = |bus.sens_ns[N_SENS_NS-1:0];
    assign w_dem_lo = |bus.sens_lo[N_SENS_LO-1:0];

    // Any phase change restarts the timer from zero.
    assign w_troca = (w_fase_nxt != r_fase);

    semaforo_timer #(
        .CNT_W       (CNT_W),
        .T_VERDE_MIN (T_VERDE_MIN),
        .T_VERDE_MAX (T_VERDE_MAX),
        .T_AMARELO   (T_AMARELO),
        .T_VERMELHO  (T_VERMELHO)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_tick         (bus.tick),
        .i_clr          (w_troca),
        .o_fim_vermelho (w_fim_vermelho),
        .o_fim_amarelo  (w_fim_amarelo),
        .o_min_verde    (w_min_verde),
        .o_max_verde    (w_max_verde)
    );

    // Next phase. The fault request overrides everything and does not wait
    // for a tick; leaving the fault always goes through full all-red.
    always_comb begin
        w_fase_nxt = r_fase;
        if (bus.falha) begin
            w_fase_nxt = c_PISCA;
        end else begin
            case (r_fase)
                c_VERM_A:   if (w_fim_vermelho) w_fase_nxt = c_NS_VERDE;
                c_NS_VERDE: if (w_dem_lo && ((w_min_verde && !w_dem_ns) || w_max_verde))
                                w_fase_nxt = c_NS_AMAR;
                c_NS_AMAR:  if (w_fim_amarelo)  w_fase_nxt = c_VERM_B;
                c_VERM_B:   if (w_fim_vermelho) w_fase_nxt = c_LO_VERDE;
                c_LO_VERDE: if (w_dem_ns && ((w_min_verde && !w_dem_lo) || w_max_verde))
                                w_fase_nxt = c_LO_AMAR;
                c_LO_AMAR:  if (w_fim_amarelo)  w_fase_nxt = c_VERM_A;
                c_PISCA:    w_fase_nxt = c_VERM_A;
                default:    w_fase_nxt = c_VERM_A;
            endcase
        end
    end

    // Flash phase: starts lit on entry, toggles per tick while flashing,
    // held at zero outside the fault mode.
    always_comb begin
        w_pisca_nxt = 1'b0;
        if (w_fase_nxt == c_PISCA) begin
            w_pisca_nxt = (r_fase != c_PISCA) ? 1'b1 : (r_pisca ^ bus.tick);
        end
    end

    // Lamps are decoded from the next-state values so the registered lamps
    // always match the registered phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fase    <= c_VERM_A;
            r_pisca   <= 1'b0;
            r_lamp_ns <= c_LAMP_VERMELHO;
            r_lamp_lo <= c_LAMP_VERMELHO;
        end else begin
            r_fase    <= w_fase_nxt;
            r_pisca   <= w_pisca_nxt;
            r_lamp_ns <= decodifica_lampada(w_fase_nxt, w_pisca_nxt, c_NS_VERDE, c_NS_AMAR);
            r_lamp_lo <= decodifica_lampada(w_fase_nxt, w_pisca_nxt, c_LO_VERDE, c_LO_AMAR);
        end
    end

    assign bus.ns_verde    = r_lamp_ns.verde;
    assign bus.ns_amarelo  = r_lamp_ns.amarelo;
    assign bus.ns_vermelho = r_lamp_ns.vermelho;
    assign bus.lo_verde    = r_lamp_lo.verde;
    assign bus.lo_amarelo  = r_lamp_lo.amarelo;
    assign bus.lo_vermelho = r_lamp_lo.vermelho;
    assign bus.fase        = r_fase;

endmodule
`default_nettype wire

// File: tb/tb_semaforo_temporizado.sv
`default_nettype none
// ============================================================================
// Module      : tb_semaforo_temporizado
// Description : Self-checking bench for semaforo_temporizado. A reference
//               model advances on every rising edge from the sampled inputs
//               and queues the expected {fase, NS lamps, LO lamps} word; a
//               monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semaforo_temporizado;

    localparam int T_MIN = 8;
    localparam int T_MAX = 32;
    localparam int T_AM  = 3;
    localparam int T_VM  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    semaforo_if #(.N_SENS_NS(2), .N_SENS_LO(2)) bus ();

    semaforo_temporizado #(
        .N_SENS_NS   (2),
        .N_SENS_LO   (2),
        .T_VERDE_MIN (T_MIN),
        .T_VERDE_MAX (T_MAX),
        .T_AMARELO   (T_AM),
        .T_VERMELHO  (T_VM),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] sb[$];
    int         cyc      = 0;
    int         tick_div = 1;
    bit         tick_rand = 1'b0;
    bit         jitter    = 1'b0;

    // Reference model: phase code, ticks spent in the phase, flash lamp.
    int m_ph    = 0;
    int m_t     = 0;
    bit m_blink = 1'b0;

    // Lamp triplets are {green, yellow, red}.
    function automatic logic [8:0] exp_word(input int ph, input bit blink);
        logic [2:0] ns, lo;
        if (ph == 6) begin
            ns = {1'b0, blink, 1'b0};
            lo = ns;
        end else begin
            ns = (ph == 1) ? 3'b100 : (ph == 2) ? 3'b010 : 3'b001;
            lo = (ph == 4) ? 3'b100 : (ph == 5) ? 3'b010 : 3'b001;
        end
        return {3'(ph), ns, lo};
    endfunction

    always @(posedge clk) begin
        bit dn, dl, go;
        int n;
        dn = |bus.sens_ns;
        dl = |bus.sens_lo;
        go = 1'b0;
        if (!rst_n) begin
            m_ph = 0; m_t = 0; m_blink = 1'b0;
        end else if (bus.falha) begin
            if (m_ph != 6) begin
                m_ph = 6; m_t = 0; m_blink = 1'b1;
            end else if (bus.tick) begin
                m_blink = !m_blink;
            end
        end else if (m_ph == 6) begin
            m_ph = 0; m_t = 0; m_blink = 1'b0;
        end else if (bus.tick) begin
            n = m_t + 1;
            case (m_ph)
                0, 3:    go = (n >= T_VM);
                2, 5:    go = (n >= T_AM);
                1:       go = dl && ((n >= T_MIN && !dn) || n >= T_MAX);
                default: go = dn && ((n >= T_MIN && !dl) || n >= T_MAX);
            endcase
            if (go) begin
                m_ph = (m_ph + 1) % 6;
                m_t  = 0;
            end else begin
                m_t = n;
            end
        end
        sb.push_back(exp_word(m_ph, m_blink));
    end

    logic [8:0] mon_act, mon_exp;

    always @(negedge clk) begin
        mon_act = {bus.fase, bus.ns_verde, bus.ns_amarelo, bus.ns_vermelho,
                   bus.lo_verde, bus.lo_amarelo, bus.lo_vermelho};
        checks++;
        if (bus.ns_verde && bus.lo_verde) begin
            failures++;
            $display("FAIL both_green cyc=%0d ns_verde=%b lo_verde=%b required not both 1",
                     cyc, bus.ns_verde, bus.lo_verde);
        end
        if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            checks++;
            if (mon_act !== mon_exp) begin
                failures++;
                $display("FAIL scoreboard cyc=%0d actual fase/ns/lo=%b expected=%b",
                         cyc, mon_act, mon_exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (tick_rand) bus.tick = ($urandom_range(2) != 0);
            else           bus.tick = ((cyc % tick_div) == 0);
            if (jitter) begin
                bus.sens_ns = 2'($urandom);
                bus.sens_lo = 2'($urandom);
            end
        end
    endtask

    task automatic wait_fase(input logic [2:0] f, input int budget, input string name);
        int k = 0;
        while (bus.fase != f && k < budget) begin
            step(1);
            k++;
        end
        checks++;
        if (bus.fase != f) begin
            failures++;
            $display("FAIL %s fase=%0d required=%0d within %0d cycles", name, bus.fase, f, budget);
        end
    endtask

    // Called on the first cycle a phase is visible; counts its length.
    task automatic measure(input logic [2:0] f, input int expd, input string name);
        int n = 0;
        while (bus.fase == f && n < expd + 50) begin
            step(1);
            n++;
        end
        checks++;
        if (n != expd) begin
            failures++;
            $display("FAIL %s duration=%0d required=%0d", name, n, expd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick    = 1'b1;
        bus.sens_ns = 2'b00;
        bus.sens_lo = 2'b00;
        bus.falha   = 1'b0;

        // Reset, then idle: 2 cycles all-red, NS green held indefinitely.
        step(3);
        rst_n = 1'b1;
        measure(3'd0, T_VM, "reset_clearance");
        step(100);
        checks++;
        if (bus.fase != 3'd1 || bus.lo_verde) begin
            failures++;
            $display("FAIL idle_hold fase=%0d lo_verde=%b required fase=1 lo_verde=0",
                     bus.fase, bus.lo_verde);
        end

        // Min green: LO demand only, from the start of NS green.
        bus.sens_lo = 2'b01;
        wait_fase(3'd4, 20, "reach_lo_green");
        bus.sens_ns = 2'b01;
        bus.sens_lo = 2'b00;
        wait_fase(3'd0, 20, "reach_verm_a");
        bus.sens_ns = 2'b00;
        bus.sens_lo = 2'b01;
        wait_fase(3'd1, 10, "reach_ns_green");
        measure(3'd1, T_MIN, "min_green_ns");
        measure(3'd2, T_AM,  "yellow_ns");
        measure(3'd3, T_VM,  "clearance_b");
        wait_fase(3'd4, 0,   "lo_after_clearance");

        // Max green with conflicting demand, both sides.
        bus.sens_ns = 2'b11;
        bus.sens_lo = 2'b10;
        measure(3'd4, T_MAX, "max_green_lo");
        measure(3'd5, T_AM,  "yellow_lo");
        measure(3'd0, T_VM,  "clearance_a");
        measure(3'd1, T_MAX, "max_green_ns");

        // Tick every 4th cycle: all durations scale by 4.
        tick_div    = 4;
        bus.sens_ns = 2'b01;
        bus.sens_lo = 2'b00;
        wait_fase(3'd4, 100, "slow_reach_lo");
        measure(3'd4, 4 * T_MIN, "slow_min_green_lo");
        jitter = 1'b1;
        measure(3'd5, 4 * T_AM, "slow_yellow_jitter");
        jitter      = 1'b0;
        bus.sens_ns = 2'b00;
        bus.sens_lo = 2'b00;
        measure(3'd0, 4 * T_VM, "slow_clearance");
        wait_fase(3'd1, 0, "slow_ns_green");
        tick_div = 1;
        step(20);

        // Fault in the middle of LO green.
        bus.sens_lo = 2'b01;
        wait_fase(3'd4, 40, "fault_reach_lo");
        step(3);
        bus.falha = 1'b1;
        step(1);
        checks++;
        if (bus.fase != 3'd6 || !bus.ns_amarelo || !bus.lo_amarelo ||
            bus.ns_verde || bus.lo_verde || bus.ns_vermelho || bus.lo_vermelho) begin
            failures++;
            $display("FAIL pisca_entry fase=%0d amarelos=%b%b required fase=6 amarelos=11 rest 0",
                     bus.fase, bus.ns_amarelo, bus.lo_amarelo);
        end
        step(7);
        bus.falha = 1'b0;
        step(1);
        measure(3'd0, T_VM, "clearance_after_pisca");
        wait_fase(3'd1, 0, "green_after_pisca");

        // Asynchronous reset in NS yellow.
        wait_fase(3'd2, 20, "reach_ns_yellow");
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.fase, bus.ns_verde, bus.ns_amarelo, bus.ns_vermelho,
             bus.lo_verde, bus.lo_amarelo, bus.lo_vermelho} != 9'b000_001_001) begin
            failures++;
            $display("FAIL async_reset fase=%0d ns=%b%b%b lo=%b%b%b required fase=0 ns=001 lo=001",
                     bus.fase, bus.ns_verde, bus.ns_amarelo, bus.ns_vermelho,
                     bus.lo_verde, bus.lo_amarelo, bus.lo_vermelho);
        end
        bus.sens_ns = 2'b00;
        bus.sens_lo = 2'b00;
        step(2);
        rst_n = 1'b1;
        measure(3'd0, T_VM, "restart_clearance");
        step(100);

        // Randomized traffic, ticks and short faults.
        tick_rand = 1'b1;
        for (int seg = 0; seg < 40; seg++) begin
            bus.sens_ns = 2'($urandom);
            bus.sens_lo = 2'($urandom);
            bus.falha   = ($urandom_range(9) == 0);
            step($urandom_range(25, 1));
        end
        tick_rand = 1'b0;
        bus.falha = 1'b0;
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
